// File: rtl/pi_hold_decoder.sv
// pi_hold_decoder
//   Registered decoder and hold tracker for the priority-interrupt path.
//   It takes an encoded level (0 = highest priority) and issues a one-cycle
//   one-hot grant. A per-level "held" flop stays set until a dismiss retires
//   the highest-priority held level.
//
// Ports
//   clk         in   system clock, rising edge
//   CROBAR      in   asynchronous active-high reset
//   set_strobe  in   grant and hold the level on set_level this cycle
//   set_level   in   [0:2] encoded level to grant
//   dismiss     in   retire the highest-priority held level
//   clear_all   in   synchronous clear of all held levels (overrides all)
//   grant       out  [0:7] one-hot pulse of the level granted last cycle
//   hold        out  [0:7] held-level vector (bit 0 = highest priority)
//   any_held    out  OR of hold
//   cur_level   out  [0:2] index of highest-priority held level, 0 if none
//   dup_err     out  pulse: strobe hit a level that stays held
module pi_hold_decoder (
   input  logic       clk,
   input  logic       CROBAR,
   input  logic       set_strobe,
   input  logic [0:2] set_level,
   input  logic       dismiss,
   input  logic       clear_all,
   output logic [0:7] grant,
   output logic [0:7] hold,
   output logic       any_held,
   output logic [0:2] cur_level,
   output logic       dup_err
);

   logic [0:7] r_hold;
   logic [0:7] r_grant;
   logic       r_any_held;
   logic [0:2] r_cur_level;
   logic       r_dup_err;

   logic [0:7] w_dec;
   logic [0:7] w_dmask;
   logic       w_found;
   logic       w_dup_n;
   logic [0:7] w_hold_n;
   logic [0:7] w_grant_n;
   logic [0:2] w_cur_n;

   // Decode the requested level to one-hot.
   always_comb begin
      w_dec            = '0;
      w_dec[set_level] = 1'b1;
   end

   // One-hot of the lowest-index (highest-priority) held bit.
   always_comb begin
      w_dmask = '0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (r_hold[i] && !w_found) begin
            w_dmask[i] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end

   // Next-state: clear_all dominates; otherwise dismiss then set, so a set
   // on the bit being dismissed wins and re-grants it.
   always_comb begin
      w_dup_n   = set_strobe & r_hold[set_level]
                  & ~(dismiss & w_dmask[set_level]) & ~clear_all;
      w_hold_n  = '0;
      w_grant_n = '0;
      if (!clear_all) begin
         w_hold_n = (r_hold & ~(dismiss ? w_dmask : 8'b0))
                    | (set_strobe ? w_dec : 8'b0);
         if (set_strobe && !w_dup_n)
            w_grant_n = w_dec;
      end
   end

   // Priority-encode the next hold so cur_level is coherent with hold.
   // Scanning from the lowest priority upward leaves the lowest index.
   always_comb begin
      w_cur_n = '0;
      for (int unsigned i = 8; i > 0; i--) begin
         if (w_hold_n[i-1])
            w_cur_n = 3'(i - 1);
      end
   end

   always_ff @(posedge clk or posedge CROBAR) begin
      if (CROBAR) begin
         r_hold      <= '0;
         r_grant     <= '0;
         r_any_held  <= 1'b0;
         r_cur_level <= '0;
         r_dup_err   <= 1'b0;
      end else begin
         r_hold      <= w_hold_n;
         r_grant     <= w_grant_n;
         r_any_held  <= |w_hold_n;
         r_cur_level <= w_cur_n;
         r_dup_err   <= w_dup_n;
      end
   end

   assign grant     = r_grant;
   assign hold      = r_hold;
   assign any_held  = r_any_held;
   assign cur_level = r_cur_level;
   assign dup_err   = r_dup_err;

endmodule

// File: tb/tb_pi_hold_decoder.sv
module tb_pi_hold_decoder;

   logic       clk = 1'b0;
   logic       CROBAR;
   logic       set_strobe;
   logic [0:2] set_level;
   logic       dismiss;
   logic       clear_all;
   logic [0:7] grant;
   logic [0:7] hold;
   logic       any_held;
   logic [0:2] cur_level;
   logic       dup_err;

   always #5 clk = ~clk;

   pi_hold_decoder dut (
      .clk        (clk),
      .CROBAR     (CROBAR),
      .set_strobe (set_strobe),
      .set_level  (set_level),
      .dismiss    (dismiss),
      .clear_all  (clear_all),
      .grant      (grant),
      .hold       (hold),
      .any_held   (any_held),
      .cur_level  (cur_level),
      .dup_err    (dup_err)
   );

   typedef struct {
      logic       st;
      logic [0:2] lvl;
      logic       dis;
      logic       clr;
      logic [0:7] g;
      logic [0:7] h;
      logic       any;
      logic [0:2] cur;
      logic       dup;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(input logic st, input logic [0:2] lvl,
                               input logic dis, input logic clr,
                               input logic [0:7] g, input logic [0:7] h,
                               input logic any, input logic [0:2] cur,
                               input logic dup);
      vec_t v;
      v.st = st; v.lvl = lvl; v.dis = dis; v.clr = clr;
      v.g = g; v.h = h; v.any = any; v.cur = cur; v.dup = dup;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string nm, input logic [0:7] g, input logic [0:7] h,
                            input logic any, input logic [0:2] cur, input logic dup);
      chk({nm, " grant"},     32'(grant),     32'(g));
      chk({nm, " hold"},      32'(hold),      32'(h));
      chk({nm, " any_held"},  32'(any_held),  32'(any));
      chk({nm, " cur_level"}, 32'(cur_level), 32'(cur));
      chk({nm, " dup_err"},   32'(dup_err),   32'(dup));
   endtask

   task automatic drive(input logic st, input logic [0:2] lvl, input logic dis, input logic clr);
      set_strobe = st;
      set_level  = lvl;
      dismiss    = dis;
      clear_all  = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model state: one flag per priority level.
   bit m_held[8];

   initial begin
      bit         st, dis, clr, dup;
      bit  [2:0]  lvl;
      int         lowest, gnt, first;
      logic [0:7] eg, eh;

      CROBAR = 1'b1;
      drive(0, 0, 0, 0);
      step();
      step();
      check_all("in_reset", '0, '0, 0, 0, 0);
      CROBAR = 1'b0;
      step();
      check_all("after_reset", '0, '0, 0, 0, 0);

      // Asynchronous reset mid-cycle with levels 1 and 2 held.
      drive(1, 1, 0, 0); step();
      drive(1, 2, 0, 0); step();
      drive(0, 0, 0, 0); step();
      chk("pre_reset hold", 32'(hold), 32'(8'b0110_0000));
      #3 CROBAR = 1'b1;
      #1 check_all("async_reset", '0, '0, 0, 0, 0);
      step();
      CROBAR = 1'b0;
      step();
      check_all("reset_idle", '0, '0, 0, 0, 0);

      // Directed table from an empty hold.
      vecs.push_back(mk(1, 5, 0, 0, 8'b0000_0100, 8'b0000_0100, 1, 5, 0));
      vecs.push_back(mk(0, 0, 0, 0, 8'b0000_0000, 8'b0000_0100, 1, 5, 0));
      vecs.push_back(mk(1, 2, 0, 0, 8'b0010_0000, 8'b0010_0100, 1, 2, 0));
      vecs.push_back(mk(0, 0, 1, 0, 8'b0000_0000, 8'b0000_0100, 1, 5, 0));
      vecs.push_back(mk(0, 0, 1, 0, 8'b0000_0000, 8'b0000_0000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 8'b0000_0000, 8'b0000_0000, 0, 0, 0));
      vecs.push_back(mk(1, 2, 0, 0, 8'b0010_0000, 8'b0010_0000, 1, 2, 0));
      vecs.push_back(mk(1, 2, 1, 0, 8'b0010_0000, 8'b0010_0000, 1, 2, 0));
      vecs.push_back(mk(1, 6, 1, 0, 8'b0000_0010, 8'b0000_0010, 1, 6, 0));
      vecs.push_back(mk(1, 3, 1, 0, 8'b0001_0000, 8'b0001_0000, 1, 3, 0));
      vecs.push_back(mk(1, 3, 0, 0, 8'b0000_0000, 8'b0001_0000, 1, 3, 1));
      vecs.push_back(mk(0, 0, 0, 0, 8'b0000_0000, 8'b0001_0000, 1, 3, 0));
      vecs.push_back(mk(1, 0, 0, 0, 8'b1000_0000, 8'b1001_0000, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 8'b0100_0000, 8'b1101_0000, 1, 0, 0));
      vecs.push_back(mk(1, 2, 0, 0, 8'b0010_0000, 8'b1111_0000, 1, 0, 0));
      vecs.push_back(mk(1, 4, 0, 0, 8'b0000_1000, 8'b1111_1000, 1, 0, 0));
      vecs.push_back(mk(1, 5, 0, 0, 8'b0000_0100, 8'b1111_1100, 1, 0, 0));
      vecs.push_back(mk(1, 6, 0, 0, 8'b0000_0010, 8'b1111_1110, 1, 0, 0));
      vecs.push_back(mk(1, 7, 0, 0, 8'b0000_0001, 8'b1111_1111, 1, 0, 0));
      vecs.push_back(mk(1, 4, 1, 1, 8'b0000_0000, 8'b0000_0000, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].st, vecs[i].lvl, vecs[i].dis, vecs[i].clr);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].h, vecs[i].any,
                   vecs[i].cur, vecs[i].dup);
      end

      // All eight held, then dismisses retire levels 0..7 in order.
      for (int k = 0; k < 8; k++) begin
         drive(1, 3'(k), 0, 0);
         step();
      end
      chk("all8 hold", 32'(hold), 32'(8'hFF));
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 1, 0);
         step();
         chk($sformatf("drain%0d hold", k), 32'(hold), 32'(8'hFF >> (k + 1)));
         chk($sformatf("drain%0d cur", k), 32'(cur_level), (k < 7) ? 32'(k + 1) : 32'd0);
         chk($sformatf("drain%0d any", k), 32'(any_held), (k < 7) ? 32'd1 : 32'd0);
      end

      // Reset while a grant pulse is visible kills it at once.
      drive(1, 4, 0, 0);
      step();
      chk("pulse grant", 32'(grant), 32'(8'b0000_1000));
      CROBAR = 1'b1;
      #1 check_all("kill_pulse", '0, '0, 0, 0, 0);
      step();
      check_all("strobe_in_reset", '0, '0, 0, 0, 0);
      drive(0, 0, 0, 0);
      CROBAR = 1'b0;
      step();
      check_all("post_kill", '0, '0, 0, 0, 0);

      // Reset asserted before the edge that would have granted.
      drive(1, 3, 0, 0);
      #2 CROBAR = 1'b1;
      step();
      drive(0, 0, 0, 0);
      CROBAR = 1'b0;
      step();
      check_all("preedge_kill", '0, '0, 0, 0, 0);

      // Randomized run against the level-flag model.
      for (int i = 0; i < 8; i++) m_held[i] = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         st  = ($urandom_range(0, 3) != 0);
         lvl = 3'($urandom_range(0, 7));
         dis = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 24) == 0);
         drive(st, lvl, dis, clr);

         lowest = -1;
         for (int i = 7; i >= 0; i--) if (m_held[i]) lowest = i;
         gnt = -1;
         dup = 1'b0;
         if (clr) begin
            for (int i = 0; i < 8; i++) m_held[i] = 1'b0;
         end else begin
            dup = st && m_held[lvl] && !(dis && lowest == int'(lvl));
            if (dis && lowest >= 0) m_held[lowest] = 1'b0;
            if (st) m_held[lvl] = 1'b1;
            if (st && !dup) gnt = int'(lvl);
         end
         eg = '0;
         eh = '0;
         first = -1;
         for (int i = 0; i < 8; i++) begin
            eh[i] = m_held[i];
            if (m_held[i] && first < 0) first = i;
            if (gnt == i) eg[i] = 1'b1;
         end

         step();
         check_all($sformatf("rnd%0d", n), eg, eh, (first >= 0),
                   (first >= 0) ? 3'(first) : 3'd0, dup);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
